fetch_ctrl: RTL

- Sequences instruction fetch for the single-issue core.
- Owns the architectural PC register and issues one instruction-memory request at a time.
- Delivers fetched instructions to decode through a valid/ready handshake.
- Accepts PC redirects from the branch/jump resolution path (the next-PC mux output) and squashes any wrong-path fetch in flight.

---
 rtl/fetch_ctrl_pkg.sv | 11 +
 rtl/fetch_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch types and constants: controller state encoding, reset PC,
// the NOP used to fill an empty slot, and the PC step.
package rvnova_fetch_pkg;

  typedef enum logic [2:0] {BOOT, REQ, WAIT, FULL, FAULT} state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [31:0] PC_INC       = 32'd4;

endpackage

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch sequencer with redirect/squash.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets in FAULT.
module fetch_ctrl
  import rvnova_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic        fetch_fault
);

  state_e      state, state_n;
  logic [31:0] pc, pc_n, inst_q, inst_n, ipc_q, ipc_n, tgt;
  logic        kill, kill_n, outstanding, out_after, misalign;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    kill_n  = kill;
    inst_n  = inst_q;
    ipc_n   = ipc_q;
    // A request is in flight in WAIT, or in FAULT while a squashed one drains.
    outstanding = (state == WAIT) || (state == FAULT && kill);
    out_after   = (state == REQ && imem_gnt) || (outstanding && !imem_rvalid);
`ifdef FETCH_ALIGN_CHECK_EN
    tgt      = redirect_pc;
    misalign = |redirect_pc[1:0];
`else
    tgt      = {redirect_pc[31:2], 2'b00};
    misalign = 1'b0;
`endif
    if (redirect_valid) begin
      pc_n   = tgt;
      inst_n = NOP_INST;
      kill_n = out_after;
      if (misalign) begin
        state_n = FAULT;
        ipc_n   = redirect_pc;
      end else begin
        state_n = out_after ? WAIT : REQ;
      end
    end else begin
      case (state)
        BOOT: state_n = REQ;
        REQ:  if (imem_gnt) state_n = WAIT;
        WAIT: if (imem_rvalid) begin
          if (kill) begin
            kill_n  = 1'b0;
            state_n = REQ;
          end else begin
            inst_n  = imem_rdata;
            ipc_n   = pc;
            pc_n    = pc + PC_INC;
            state_n = FULL;
          end
        end
        FULL: if (if_ready) begin
          inst_n  = NOP_INST;
          state_n = REQ;
        end
        FAULT: if (imem_rvalid) kill_n = 1'b0;
        default: state_n = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= BOOT;
      pc     <= RESET_PC;
      kill   <= 1'b0;
      inst_q <= NOP_INST;
      ipc_q  <= 32'h0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      kill   <= kill_n;
      inst_q <= inst_n;
      ipc_q  <= ipc_n;
    end
  end

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign if_valid  = (state == FULL);
  assign if_inst   = inst_q;
  assign if_pc     = ipc_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_fault = (state == FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

endmodule
